// File: rtl/alu_result_stage.sv
// ALU result stage: derives {N,Z,C,V} from the ALU word and registers {result, flags}
// through a two-entry skid buffer so upstream ready never depends on downstream ready.
module alu_result_stage #(
    parameter int N = 64
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic [1:0]   i_alu_ctrl,
    input  logic [N-1:0] i_result,
    input  logic         i_carry_out,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [N-1:0] o_result,
    output logic [3:0]   o_flags
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t       state_reg, state_next;
    logic         push, pop;
    logic         flag_n, flag_z, flag_c, flag_v;
    logic         sign_a, sign_b, sign_r;
    logic [N+3:0] in_word;
    logic [N+3:0] head_reg, head_next;
    logic [N+3:0] skid_reg, skid_next;

    // Only the operand sign bits feed the overflow logic; the rest are intentionally unused.
    logic unused_operand_bits;
    assign unused_operand_bits = ^{i_a[N-2:0], i_b[N-2:0]};

    always_comb begin
        sign_a = i_a[N-1];
        sign_b = i_b[N-1];
        sign_r = i_result[N-1];
        flag_n = sign_r;
        flag_z = (i_result == '0);
        flag_c = ~i_alu_ctrl[1] & i_carry_out;
        flag_v = 1'b0;
        case (i_alu_ctrl)
            2'b00:   flag_v = (sign_a == sign_b) && (sign_r != sign_a);
            2'b01:   flag_v = (sign_a != sign_b) && (sign_r != sign_a);
            default: flag_v = 1'b0;
        endcase
    end

    assign in_word = {i_result, flag_n, flag_z, flag_c, flag_v};
    assign push    = i_valid && o_ready;
    assign pop     = o_valid && i_ready;

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg <= EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            EMPTY: begin
                if (push) state_next = ONE;
            end
            ONE: begin
                if (push && !pop)      state_next = TWO;
                else if (!push && pop) state_next = EMPTY;
                else                   state_next = ONE;
            end
            TWO: begin
                if (pop) state_next = ONE;
            end
            default: state_next = EMPTY;
        endcase
    end

    // Handshake outputs decode the registered state only
    always_comb begin
        o_valid = 1'b0;
        o_ready = 1'b1;
        case (state_reg)
            EMPTY: begin
                o_valid = 1'b0;
                o_ready = 1'b1;
            end
            ONE: begin
                o_valid = 1'b1;
                o_ready = 1'b1;
            end
            TWO: begin
                o_valid = 1'b1;
                o_ready = 1'b0;
            end
            default: begin
                o_valid = 1'b0;
                o_ready = 1'b1;
            end
        endcase
    end

    // head_reg is always the oldest entry; skid_reg only fills when head is stalled.
    always_comb begin
        head_next = head_reg;
        skid_next = skid_reg;
        case (state_reg)
            EMPTY: begin
                if (push) head_next = in_word;
            end
            ONE: begin
                if (push && pop) head_next = in_word;
                else if (push)   skid_next = in_word;
            end
            TWO: begin
                if (pop) head_next = skid_reg;
            end
            default: begin
                head_next = head_reg;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            head_reg <= '0;
            skid_reg <= '0;
        end else begin
            head_reg <= head_next;
            skid_reg <= skid_next;
        end
    end

    assign o_result = head_reg[N+3:4];
    assign o_flags  = head_reg[3:0];

endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 SHALL have parameter N, default 64, datapath width in bits (N >= 2).
REQ-002 SHALL have port i_clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port i_valid  input  1  upstream ALU word valid this cycle.
REQ-005 SHALL have port o_ready  output  1  stage can accept an upstream word this cycle.
REQ-006 SHALL have port i_a  input  N  ALU operand A, as presented to the ALU.
REQ-007 SHALL have port i_b  input  N  ALU operand B, un-inverted, as presented to the ALU.
REQ-008 SHALL have port i_alu_ctrl  input  2  ALU op: 00 add, 01 sub, 10 and, 11 or.
REQ-009 SHALL have port i_result  input  N  ALU result.
REQ-010 SHALL have port i_carry_out  input  1  ALU adder carry out.
REQ-011 SHALL have port o_valid  output  1  output word valid.
REQ-012 SHALL have port i_ready  input  1  downstream accepts the output word this cycle.
REQ-013 SHALL have port o_result  output  N  registered result.
REQ-014 SHALL have port o_flags  output  4  registered flags {N,Z,C,V}, bit3..bit0.

Function
REQ-015 SHALL transfer upstream when i_valid && o_ready, and downstream when o_valid && i_ready, both sampled at the rising edge.
REQ-016 SHALL compute flags at input: N = i_result[N-1]; Z = (i_result == 0).
REQ-017 SHALL set C = i_carry_out for ops 00/01; C = 0 for ops 10/11.
REQ-018 SHALL set V for op 00 = (i_a[N-1] == i_b[N-1]) && (i_result[N-1] != i_a[N-1]).
REQ-019 SHALL set V for op 01 = (i_a[N-1] != i_b[N-1]) && (i_result[N-1] != i_a[N-1]); V = 0 for ops 10/11.
REQ-020 SHALL buffer in a 2-entry FIFO (skid buffer) of {result, flags}, states EMPTY, ONE, TWO.
REQ-021 SHALL transition EMPTY->ONE on input only; ONE->TWO on input without output; ONE->EMPTY on output without input; ONE->ONE on both; TWO->ONE on output.
REQ-022 SHALL drive o_ready = 1 in EMPTY and ONE, 0 in TWO, from registered state only (no combinational path from i_ready).
REQ-023 SHALL drive o_valid = 1 in ONE and TWO; o_result/o_flags are the oldest entry.
REQ-024 SHALL give latency of 1 cycle: a word accepted at edge k appears on outputs after edge k when the buffer was EMPTY.
REQ-025 SHALL hold o_result/o_flags stable while o_valid && !i_ready.
REQ-026 SHALL preserve strict FIFO order, with no loss or duplication, under any i_valid/i_ready pattern.
REQ-027 SHALL sustain 1 word/cycle throughput while i_ready is held high.
REQ-028 SHALL ignore i_valid when o_ready = 0; upstream holds its word.

Reset
REQ-029 SHALL on i_rst = 1 asynchronously enter EMPTY: o_valid = 0, o_ready = 1, o_result = 0, o_flags = 0.
REQ-030 SHALL discard buffered words on reset asserted mid-operation; the first accept after release starts a fresh sequence.
REQ-031 SHALL accept no word in any cycle whose edge occurs while i_rst = 1.

Verification
REQ-032 SHALL be verified: N=64, op 00, A=0x7FFF_FFFF_FFFF_FFFF, B=1, result=0x8000_0000_0000_0000, carry=0 -> next cycle o_flags = 1001 (N,V).
REQ-033 SHALL be verified: op 01, A=5, B=5, result=0, carry=1 -> o_flags = 0110 (Z,C); op 10 with carry=1 -> C = 0.
REQ-034 SHALL be verified: i_ready = 0, three back-to-back words W0..W2 -> W0 and W1 are stored, o_ready = 0 and W2 is held; i_ready = 1 -> W0, W1, W2 are output in order.
REQ-035 SHALL be verified: i_valid = i_ready = 1 for 100 cycles -> 100 words are output in order, with o_valid continuously high after the first cycle.
REQ-036 SHALL be verified: i_rst pulsed while in state TWO -> o_valid = 0 and o_ready = 1 immediately, without waiting for a clock edge.
REQ-037 SHALL be verified: random i_valid/i_ready over 10k cycles -> scoreboard shows no loss, duplication or reordering, and outputs are stable under stall.
